// File: rtl/intersect_finder.sv
// Overlap of the stopped moving block with the last placed block, trimmed to whole units.
// Optional build macro PERFECT_SNAP_EN: near-aligned equal-size stops snap onto the previous block.
module intersect_finder #(
    parameter int unsigned UNIT_W = 8,
    parameter int unsigned X_W    = 9
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           stop_true,
    input  logic [X_W-1:0] moving_block_start,
    input  logic [3:0]     moving_block_size,
    input  logic [X_W-1:0] prev_block_start,
    input  logic [X_W-1:0] prev_block_end,
    input  logic [3:0]     prev_block_size,
    output logic [X_W-1:0] curr_block_start,
    output logic [X_W-1:0] curr_block_end,
    output logic [3:0]     curr_block_size,
    output logic           intersect_true,
    output logic           done_finding,
    input  logic           reset_done_finding
);

    localparam int unsigned     XW1  = X_W + 1;
    localparam logic [XW1-1:0] UNIT = XW1'(UNIT_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_COMPARE,
        S_DIVIDE,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [X_W-1:0] mv_start_q;
    logic [XW1-1:0] mv_end1_q;
    logic [X_W-1:0] pv_start_q;
    logic [X_W-1:0] pv_end_q;
    logic [3:0]     pv_size_q;
    logic [X_W-1:0] ov_start_q;
    logic [XW1-1:0] rem_q;
    logic [3:0]     units_q;
`ifdef PERFECT_SNAP_EN
    logic [3:0]     mv_size_q;
    logic [X_W-1:0] start_diff;
`endif

    logic [X_W-1:0] ov_start;
    logic [XW1-1:0] ov_end1;
    logic [XW1-1:0] pv_end1;
    logic [XW1-1:0] width;
    logic [XW1-1:0] rem_next;
    logic [3:0]     units_next;
    logic           div_last;
    logic           snap;

    // Ends are carried exclusive (end + 1) at X_W+1 bits so a zero-width block cannot wrap.
    always_comb begin
        pv_end1  = {1'b0, pv_end_q} + XW1'(1);
        ov_start = mv_start_q;
        ov_end1  = mv_end1_q;
        if (pv_size_q != '0) begin
            if (pv_start_q > mv_start_q) ov_start = pv_start_q;
            if (pv_end1 < mv_end1_q)     ov_end1  = pv_end1;
        end
        width = '0;
        if ({1'b0, ov_start} < ov_end1) width = ov_end1 - {1'b0, ov_start};
        snap = 1'b0;
`ifdef PERFECT_SNAP_EN
        start_diff = (mv_start_q >= pv_start_q) ? (mv_start_q - pv_start_q)
                                                : (pv_start_q - mv_start_q);
        snap = (pv_size_q != '0) && ({1'b0, start_diff} < UNIT) && (mv_size_q == pv_size_q);
`endif
        rem_next   = rem_q - UNIT;
        units_next = units_q + 4'd1;
        div_last   = (rem_next < UNIT) || (units_next == 4'hF);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (stop_true) state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_COMPARE;
            S_COMPARE: state_next = (snap || width < UNIT) ? S_DONE : S_DIVIDE;
            S_DIVIDE:  if (div_last) state_next = S_DONE;
            S_DONE:    if (reset_done_finding) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mv_start_q       <= '0;
            mv_end1_q        <= '0;
            pv_start_q       <= '0;
            pv_end_q         <= '0;
            pv_size_q        <= '0;
            ov_start_q       <= '0;
            rem_q            <= '0;
            units_q          <= '0;
`ifdef PERFECT_SNAP_EN
            mv_size_q        <= '0;
`endif
            curr_block_start <= '0;
            curr_block_end   <= '0;
            curr_block_size  <= '0;
            intersect_true   <= 1'b0;
            done_finding     <= 1'b0;
        end else begin
            case (state)
                S_CAPTURE: begin
                    mv_start_q <= moving_block_start;
                    mv_end1_q  <= {1'b0, moving_block_start} + XW1'(moving_block_size) * UNIT;
                    pv_start_q <= prev_block_start;
                    pv_end_q   <= prev_block_end;
                    pv_size_q  <= prev_block_size;
`ifdef PERFECT_SNAP_EN
                    mv_size_q  <= moving_block_size;
`endif
                end
                S_COMPARE: begin
                    if (snap) begin
                        curr_block_start <= pv_start_q;
                        curr_block_end   <= pv_end_q;
                        curr_block_size  <= pv_size_q;
                        intersect_true   <= 1'b1;
                        done_finding     <= 1'b1;
                    end else if (width < UNIT) begin
                        curr_block_start <= '0;
                        curr_block_end   <= '0;
                        curr_block_size  <= '0;
                        intersect_true   <= 1'b0;
                        done_finding     <= 1'b1;
                    end else begin
                        ov_start_q <= ov_start;
                        rem_q      <= width;
                        units_q    <= '0;
                    end
                end
                S_DIVIDE: begin
                    rem_q   <= rem_next;
                    units_q <= units_next;
                    if (div_last) begin
                        curr_block_start <= ov_start_q;
                        curr_block_end   <= X_W'({1'b0, ov_start_q} + XW1'(units_next) * UNIT - XW1'(1));
                        curr_block_size  <= units_next;
                        intersect_true   <= 1'b1;
                        done_finding     <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (reset_done_finding) done_finding <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_intersect_finder.sv
// Self-checking bench for intersect_finder: directed vector table, hand-written DONE/reset
// sequences and randomized operations against an arithmetic reference model.
module tb_intersect_finder;

    localparam int unsigned UNIT_W = 8;
    localparam int unsigned X_W    = 9;
    localparam int          MAX_LAT = 40;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           stop_true = 1'b0;
    logic [X_W-1:0] moving_block_start = '0;
    logic [3:0]     moving_block_size = '0;
    logic [X_W-1:0] prev_block_start = '0;
    logic [X_W-1:0] prev_block_end = '0;
    logic [3:0]     prev_block_size = '0;
    logic [X_W-1:0] curr_block_start;
    logic [X_W-1:0] curr_block_end;
    logic [3:0]     curr_block_size;
    logic           intersect_true;
    logic           done_finding;
    logic           reset_done_finding = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    intersect_finder #(.UNIT_W(UNIT_W), .X_W(X_W)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .stop_true          (stop_true),
        .moving_block_start (moving_block_start),
        .moving_block_size  (moving_block_size),
        .prev_block_start   (prev_block_start),
        .prev_block_end     (prev_block_end),
        .prev_block_size    (prev_block_size),
        .curr_block_start   (curr_block_start),
        .curr_block_end     (curr_block_end),
        .curr_block_size    (curr_block_size),
        .intersect_true     (intersect_true),
        .done_finding       (done_finding),
        .reset_done_finding (reset_done_finding)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ms, msz, ps, pe, psz;
        int es, ee, esz, ehit, elat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: clipped overlap interval, whole units by integer division, latency 3 + units.
    function automatic vec_t model(input int ms, input int msz, input int ps, input int pe, input int psz);
        vec_t r;
        int os, oe, w, u;
        r.ms = ms; r.msz = msz; r.ps = ps; r.pe = pe; r.psz = psz;
        os = ms;
        oe = ms + msz * UNIT_W - 1;
        if (psz != 0) begin
            if (ps > os) os = ps;
            if (pe < oe) oe = pe;
        end
        w = (oe >= os) ? oe - os + 1 : 0;
        u = w / UNIT_W;
        if (u > 15) u = 15;
        if (u == 0) begin
            r.es = 0; r.ee = 0; r.esz = 0; r.ehit = 0; r.elat = 3;
        end else begin
            r.es = os; r.ee = (os + u * UNIT_W - 1) % (1 << X_W); r.esz = u; r.ehit = 1; r.elat = 3 + u;
        end
`ifdef PERFECT_SNAP_EN
        if (psz != 0 && ((ms > ps) ? ms - ps : ps - ms) < UNIT_W && msz == psz) begin
            r.es = ps; r.ee = pe; r.esz = psz; r.ehit = 1; r.elat = 3;
        end
`endif
        return r;
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        moving_block_start = X_W'(v.ms);
        moving_block_size  = 4'(v.msz);
        prev_block_start   = X_W'(v.ps);
        prev_block_end     = X_W'(v.pe);
        prev_block_size    = 4'(v.psz);
        stop_true          = 1'b1;
    endtask

    // Counts rising edges from the stop sampling edge until done_finding is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < MAX_LAT) begin
            @(negedge clk);
            lat++;
            stop_true = 1'b0;
            if (done_finding) break;
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, ".start"}, 32'(curr_block_start), 32'(v.es));
        check({tag, ".end"},   32'(curr_block_end),   32'(v.ee));
        check({tag, ".size"},  32'(curr_block_size),  32'(v.esz));
        check({tag, ".hit"},   32'(intersect_true),   32'(v.ehit));
    endtask

    task automatic ack(input string tag, input vec_t v);
        reset_done_finding = 1'b1;
        @(negedge clk);
        reset_done_finding = 1'b0;
        check({tag, ".ack_done"}, 32'(done_finding), 32'd0);
        check({tag, ".ack_keep_start"}, 32'(curr_block_start), 32'(v.es));
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        apply(v);
        wait_done(lat);
        check({tag, ".latency"}, 32'(lat), 32'(v.elat));
        check_outputs(tag, v);
        ack(tag, v);
    endtask

    initial begin
        vec_t v;
        int lat;
        int ok;

        vecs[0] = '{40, 6, 0, 0, 0,        40, 87, 6, 1, 9};
        vecs[1] = '{56, 6, 40, 87, 6,      56, 87, 4, 1, 7};
        vecs[2] = '{96, 6, 40, 87, 6,      0, 0, 0, 0, 3};
`ifdef PERFECT_SNAP_EN
        vecs[3] = '{44, 6, 40, 87, 6,      40, 87, 6, 1, 3};
        vecs[7] = '{98, 15, 100, 219, 15,  100, 219, 15, 1, 3};
`else
        vecs[3] = '{44, 6, 40, 87, 6,      44, 83, 5, 1, 8};
        vecs[7] = '{98, 15, 100, 219, 15,  100, 211, 14, 1, 17};
`endif
        vecs[4] = '{87, 2, 40, 87, 6,      0, 0, 0, 0, 3};
        vecs[5] = '{20, 3, 40, 87, 6,      0, 0, 0, 0, 3};
        vecs[6] = '{0, 15, 40, 87, 6,      40, 87, 6, 1, 9};
        vecs[8] = '{500, 15, 0, 0, 0,      500, 107, 15, 1, 18};

        repeat (2) @(negedge clk);
        check("reset.done",  32'(done_finding),     32'd0);
        check("reset.hit",   32'(intersect_true),   32'd0);
        check("reset.start", 32'(curr_block_start), 32'd0);
        check("reset.end",   32'(curr_block_end),   32'd0);
        check("reset.size",  32'(curr_block_size),  32'd0);
        resetn = 1'b1;

        // Acknowledge outside DONE must do nothing.
        reset_done_finding = 1'b1;
        repeat (2) @(negedge clk);
        reset_done_finding = 1'b0;
        check("idle_ack.done", 32'(done_finding), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Held in DONE with stop toggling, then ack together with stop.
        v = vecs[1];
        apply(v);
        wait_done(lat);
        check("hold.latency", 32'(lat), 32'(v.elat));
        for (int c = 0; c < 5; c++) begin
            stop_true = ~stop_true;
            @(negedge clk);
            check("hold.done", 32'(done_finding), 32'd1);
            check_outputs("hold", v);
        end
        stop_true = 1'b1;
        reset_done_finding = 1'b1;
        @(negedge clk);
        reset_done_finding = 1'b0;
        check("ack_stop.done", 32'(done_finding), 32'd0);
        check_outputs("ack_stop.keep", v);
        wait_done(lat);
        check("ack_stop.restart_latency", 32'(lat), 32'(v.elat));
        check_outputs("ack_stop.restart", v);
        ack("ack_stop", v);

        // Asynchronous reset in the middle of DIVIDE.
        v = vecs[0];
        apply(v);
        repeat (5) @(negedge clk);
        stop_true = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("midreset.done",  32'(done_finding),     32'd0);
        check("midreset.hit",   32'(intersect_true),   32'd0);
        check("midreset.start", 32'(curr_block_start), 32'd0);
        check("midreset.end",   32'(curr_block_end),   32'd0);
        check("midreset.size",  32'(curr_block_size),  32'd0);
        @(negedge clk);
        resetn = 1'b1;
        ok = 1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done_finding !== 1'b0) ok = 0;
        end
        check("midreset.no_result", 32'(ok), 32'd1);
        run_vec("after_reset", vecs[0]);

        for (int n = 0; n < 40; n++) begin
            int ms, msz, ps, psz, pe;
            ms  = int'($urandom_range(0, 511));
            msz = int'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) begin
                ps = 0; pe = 0; psz = 0;
            end else begin
                psz = int'($urandom_range(1, 15));
                ps  = int'($urandom_range(0, 512 - psz * UNIT_W));
                pe  = ps + psz * UNIT_W - 1;
                if ($urandom_range(0, 2) == 0) begin
                    msz = psz;
                    ms  = ps + int'($urandom_range(0, 20)) - 10;
                    if (ms < 0) ms = 0;
                end
            end
            run_vec($sformatf("rand%0d", n), model(ms, msz, ps, pe, psz));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/intersect_finder.md
Name: intersect_finder

Overview:
Stage directly upstream of the block tracker. When the player stops the moving block, it computes the overlap of the moving block with the previously placed block. It then trims the result to whole block units and presents curr_block_start/end/size, intersect_true and done_finding to the tracker. Results are held until the control FSM acknowledges them with reset_done_finding.

Parameters:
UNIT_W, 8, pixels per block unit (power of two not required)
X_W, 9, pixel x-coordinate width

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
stop_true  in  1  player stop request (level; sampled only in IDLE)
moving_block_start  in  X_W  left pixel x of the moving block
moving_block_size  in  4  moving block width in units
prev_block_start  in  X_W  left x of the last placed block (from tracker)
prev_block_end  in  X_W  right x of the last placed block, inclusive
prev_block_size  in  4  units of the last placed block; 0 = no block placed yet
curr_block_start  out  X_W  left x of the trimmed block
curr_block_end  out  X_W  right x of the trimmed block, inclusive
curr_block_size  out  4  trimmed width in units
intersect_true  out  1  1 = blocks overlap by at least one unit
done_finding  out  1  result valid, held until acknowledged
reset_done_finding  in  1  acknowledge from the control FSM

Behaviour:
- Reset: asynchronous, active-low. All outputs 0 and state IDLE. A reset mid-operation aborts the computation with no result.
- All outputs are registered and change only on entry to DONE or on reset.
- States: IDLE -> CAPTURE -> COMPARE -> DIVIDE -> DONE -> IDLE.
- IDLE:
  - Wait for stop_true=1.
  - stop_true is ignored in every other state.
- CAPTURE (1 cycle):
  - Latch moving_block_start.
  - mv_end = start + size*UNIT_W - 1, computed at X_W+1 bits.
  - Latch the prev_block_* values.
- COMPARE (1 cycle):
  - If prev_block_size==0: ov_start=mv_start, ov_end=mv_end.
  - Otherwise: ov_start = max(mv_start, prev_start), ov_end = min(mv_end, prev_end).
  - If ov_start > ov_end: miss. Skip DIVIDE and go to DONE with width=0.
  - Otherwise: width = ov_end - ov_start + 1.
- DIVIDE (one cycle per unit):
  - Each cycle: while remainder >= UNIT_W, subtract UNIT_W and increment the unit count.
  - Leave when remainder < UNIT_W.
  - Unit count saturates at 15.
  - Latency from stop_true sample to done_finding = 3 + units cycles.
- DONE:
  - If units==0: intersect_true=0, curr_block_start/end/size=0.
  - Otherwise: intersect_true=1, curr_block_start=ov_start, curr_block_size=units, curr_block_end = ov_start + units*UNIT_W - 1. This trims the fractional unit from the right.
  - done_finding=1 and all outputs held stable.
  - On reset_done_finding=1: done_finding=0 next cycle, go to IDLE. Data outputs keep their values.
  - If reset_done_finding and stop_true are both high in DONE: acknowledge only; the new stop is sampled from IDLE afterwards.
- reset_done_finding outside DONE: no effect.
- Exact edge touch (ov_start==ov_end): width 1, below UNIT_W, so treated as a miss.

Optional Feature:
PERFECT_SNAP_EN
- Defined:
  - In COMPARE, if prev_block_size!=0 and |mv_start - prev_start| < UNIT_W and moving_block_size==prev_block_size, output prev_block_start/end/size unchanged with intersect_true=1.
  - This path skips DIVIDE (latency 3 cycles).
- Undefined: no snapping; normal overlap arithmetic always applies.

Test Plan:
1. prev_size=0, moving start=40, size=6 -> done_finding after 9 cycles; curr 40..87, size 6, intersect_true=1.
2. prev 40..87 size 6, moving start=56 size 6 -> curr 56..87, size 4, intersect_true=1.
3. prev 40..87 size 6, moving start=96 -> intersect_true=0, curr start/end/size=0, done_finding after 3 cycles.
4. Hold reset_done_finding=0 for 5 cycles in DONE while toggling stop_true -> outputs stable, no restart. Assert ack -> done_finding=0 next cycle.
5. Pulse resetn low during DIVIDE of scenario 1 -> all outputs 0 asynchronously, state IDLE, no done_finding.
6. prev 40..87 size 6, moving start=44 size 6:
   - with PERFECT_SNAP_EN -> curr 40..87, size 6;
   - without -> curr 44..83, size 5.
